present_key_sched: RTL

PRESENT_KEY_SCHED -- requirements
Module: present_key_sched

---
 rtl/present_key_sched_pkg.sv | 60 ++++++
 rtl/present_key_sched_sbox4.sv | 15 +
 rtl/present_key_sched.sv | 112 +++++++++++
 3 files changed

// File: rtl/present_key_sched_pkg.sv
// PRESENT-80 key schedule shared definitions: S-box tables, FSM state type,
// widths and the forward/inverse key-register step functions.
package present_key_sched_pkg;

    localparam int unsigned KEY_W  = 80;
    localparam int unsigned RK_W   = 64;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned RCON_W = 5;

    // Nibble x of each table holds S(x) / Sinv(x).
    localparam logic [63:0] SBOX_TBL     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] SBOX_INV_TBL = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRECOMP,
        ST_EMIT,
        ST_DONE
    } ks_state_t;

    function automatic logic [3:0] sbox_lookup(input logic [3:0] x, input logic inv);
        if (inv)
            sbox_lookup = SBOX_INV_TBL[{x, 2'b00} +: 4];
        else
            sbox_lookup = SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    // After rotate-left-61 the top nibble comes from bits 18:15 of the old key.
    function automatic logic [3:0] fwd_sbox_in(input logic [KEY_W-1:0] k);
        fwd_sbox_in = k[18:15];
    endfunction

    // The inverse step undoes the S-box before rotating back, so it reads the top nibble.
    function automatic logic [3:0] inv_sbox_in(input logic [KEY_W-1:0] k);
        inv_sbox_in = k[79:76];
    endfunction

    // Forward step: rotate left 61, substitute top nibble (s = S(k[18:15])), xor round counter.
    function automatic logic [KEY_W-1:0] key_step_fwd(input logic [KEY_W-1:0] k,
                                                      input logic [3:0]       s,
                                                      input logic [RCON_W-1:0] rc);
        logic [KEY_W-1:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = s;
        t[19:15]   = t[19:15] ^ rc;
        key_step_fwd = t;
    endfunction

    // Inverse step: xor counter back out, un-substitute (s = Sinv(k[79:76])), rotate right 61.
    function automatic logic [KEY_W-1:0] key_step_inv(input logic [KEY_W-1:0] k,
                                                      input logic [3:0]       s,
                                                      input logic [RCON_W-1:0] rc);
        logic [KEY_W-1:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ rc;
        t[79:76]   = s;
        key_step_inv = {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/present_key_sched_sbox4.sv
// 4-bit PRESENT S-box with inverse select; one instance serves both step directions.
//   din    : nibble in
//   inv    : 1 = inverse S-box
//   dout_c : substituted nibble (combinational)
module present_sbox4
    import present_key_sched_pkg::*;
(
    input  logic [3:0] din,
    input  logic       inv,
    output logic [3:0] dout_c
);

    assign dout_c = sbox_lookup(din, inv);

endmodule

// File: rtl/present_key_sched.sv
// PRESENT-80 round-key generator emitting ROUNDS keys in forward or inverse order
// over a valid/ready handshake.
//   clk, iReset          : clock, synchronous active-high reset
//   key, control, start  : master key, order select (1 = inverse), run request
//   rk_ready             : consumer accepts current key
//   rk, rk_valid, rk_idx : current round key, valid, round number
//   busy, done           : run in progress, one-cycle completion pulse
module present_key_sched
    import present_key_sched_pkg::*;
#(
    parameter int unsigned ROUNDS = 32
) (
    input  logic              clk,
    input  logic              iReset,
    input  logic [KEY_W-1:0]  key,
    input  logic              control,
    input  logic              start,
    input  logic              rk_ready,
    output logic [RK_W-1:0]   rk,
    output logic              rk_valid,
    output logic [IDX_W-1:0]  rk_idx,
    output logic              busy,
    output logic              done
);

    ks_state_t          state;
    logic [KEY_W-1:0]   k_q;
    logic               ctrl_q;

    logic               inv_step_c;
    logic [3:0]         sbox_in_c;
    logic [3:0]         sbox_out_c;
    logic [RCON_W-1:0]  rcon_c;
    logic [KEY_W-1:0]   k_step_c;
    logic               last_c;

    // Step direction: PRECOMP always walks forward; EMIT follows the latched order.
    always_comb begin
        inv_step_c = (state == ST_EMIT) && ctrl_q;
        sbox_in_c  = inv_step_c ? inv_sbox_in(k_q) : fwd_sbox_in(k_q);
        rcon_c     = inv_step_c ? RCON_W'(rk_idx - IDX_W'(1)) : RCON_W'(rk_idx);
        k_step_c   = inv_step_c ? key_step_inv(k_q, sbox_out_c, rcon_c)
                                : key_step_fwd(k_q, sbox_out_c, rcon_c);
        last_c     = ctrl_q ? (rk_idx == IDX_W'(1)) : (rk_idx == IDX_W'(ROUNDS));
    end

    present_sbox4 u_sbox (
        .din    (sbox_in_c),
        .inv    (inv_step_c),
        .dout_c (sbox_out_c)
    );

    // Round key is the top 64 bits of the key register, no output stage.
    assign rk = k_q[KEY_W-1 -: RK_W];

    // Control FSM and key register.
    always_ff @(posedge clk) begin
        if (iReset) begin
            state    <= ST_IDLE;
            k_q      <= '0;
            ctrl_q   <= 1'b0;
            rk_idx   <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        k_q      <= key;
                        ctrl_q   <= control;
                        rk_idx   <= IDX_W'(1);
                        busy     <= 1'b1;
                        rk_valid <= ~control;
                        state    <= control ? ST_PRECOMP : ST_EMIT;
                    end
                end
                ST_PRECOMP: begin
                    // rk_idx doubles as the forward round counter while precomputing.
                    k_q    <= k_step_c;
                    rk_idx <= rk_idx + IDX_W'(1);
                    if (rk_idx == IDX_W'(ROUNDS - 1)) begin
                        rk_valid <= 1'b1;
                        state    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready) begin
                        if (last_c) begin
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            k_q    <= k_step_c;
                            rk_idx <= ctrl_q ? rk_idx - IDX_W'(1) : rk_idx + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
